// File: rtl/kgp_risc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// function codes and the mux select values driven toward the datapath.
package kgp_risc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_MEM  = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_JR   = 3'b100;
  localparam logic [2:0] OP_BRS  = 3'b101;
  localparam logic [2:0] OP_RSV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Flag-based branches (OP_BR)
  localparam logic [3:0] F_BR_ALWAYS = 4'd0;
  localparam logic [3:0] F_BR_LINK   = 4'd1;
  localparam logic [3:0] F_BR_CARRY  = 4'd2;
  localparam logic [3:0] F_BR_NCARRY = 4'd3;

  // Register-sign branches (OP_BRS)
  localparam logic [3:0] F_BS_ZERO  = 4'd0;
  localparam logic [3:0] F_BS_NZERO = 4'd1;
  localparam logic [3:0] F_BS_NEG   = 4'd2;
  localparam logic [3:0] F_BS_POS   = 4'd3;

  localparam logic [1:0] PC_SEL_INC   = 2'd0;
  localparam logic [1:0] PC_SEL_LABEL = 2'd1;
  localparam logic [1:0] PC_SEL_RS    = 2'd2;

  localparam logic [1:0] RF_WSEL_ALU  = 2'd0;
  localparam logic [1:0] RF_WSEL_MEM  = 2'd1;
  localparam logic [1:0] RF_WSEL_LINK = 2'd2;

  function automatic logic is_flow_op(input logic [2:0] op);
    return (op == OP_BR) || (op == OP_JR) || (op == OP_BRS);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-condition evaluation: decides whether a control-flow instruction is
// taken and flags function codes that have no defined meaning.
module branch_cond
  import kgp_risc_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [3:0] func,
  input  logic       carry,
  input  logic       rs_zero,
  input  logic       rs_neg,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_BR: begin
        case (func)
          F_BR_ALWAYS, F_BR_LINK: taken = 1'b1;
          F_BR_CARRY:             taken = carry;
          F_BR_NCARRY:            taken = !carry;
          default:                illegal = 1'b1;
        endcase
      end
      OP_JR: taken = 1'b1;
      OP_BRS: begin
        case (func)
          F_BS_ZERO:  taken = rs_zero;
          F_BS_NZERO: taken = !rs_zero;
          F_BS_NEG:   taken = rs_neg;
          F_BS_POS:   taken = !rs_neg && !rs_zero;
          default:    illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath strobes from the state and latched fields.
module multi_cycle_ctrl
  import kgp_risc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [3:0] func,
  input  logic       carry,
  input  logic       rs_zero,
  input  logic       rs_neg,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       alu_b_sel,
  output logic       flag_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [1:0] pc_sel,
  output logic [1:0] rf_wsel,
  output logic [2:0] state,
  output logic       halted,
  output logic       err
);

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     cur_state, nxt_state;
  logic [2:0] op_q;
  logic [3:0] func_q;
  logic [3:0] wait_cnt;
  logic       taken, illegal;
  logic       mem_timeout, set_err;

  branch_cond u_branch_cond (
    .opcode  (op_q),
    .func    (func_q),
    .carry   (carry),
    .rs_zero (rs_zero),
    .rs_neg  (rs_neg),
    .taken   (taken),
    .illegal (illegal)
  );

  assign mem_timeout = (cur_state == S_MEM) && !dmem_ack && (wait_cnt == WAIT_LAST);
  assign set_err     = ((cur_state == S_EXEC) && (illegal || op_q == OP_RSV)) || mem_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      op_q      <= '0;
      func_q    <= '0;
      wait_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) begin
        op_q   <= opcode;
        func_q <= func;
      end
      if (cur_state == S_MEM && !dmem_ack) wait_cnt <= wait_cnt + 4'd1;
      else                                 wait_cnt <= '0;
      err <= err | set_err;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   if (start) nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: nxt_state = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ALU, OP_IMM: nxt_state = S_WB;
          OP_MEM:         nxt_state = S_MEM;
          OP_HALT:        nxt_state = S_HALT;
          default:        nxt_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)         nxt_state = func_q[0] ? S_FETCH : S_WB;
        else if (mem_timeout) nxt_state = S_HALT;
      end
      S_WB:    nxt_state = S_FETCH;
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Memory handshake: dmem_req (with dmem_we) is held every MEM cycle until
  // the cycle in which dmem_ack is also high; that cycle completes the access.
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    alu_b_sel = 1'b0;
    flag_we   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_sel    = PC_SEL_INC;
    rf_wsel   = RF_WSEL_ALU;
    case (cur_state)
      S_FETCH: ir_we = 1'b1;
      S_EXEC: begin
        if (op_q == OP_ALU || op_q == OP_IMM) flag_we = 1'b1;
        if (op_q == OP_IMM || op_q == OP_MEM) alu_b_sel = 1'b1;
        if (is_flow_op(op_q) || op_q == OP_RSV) begin
          pc_we = 1'b1;
          if (taken) pc_sel = (op_q == OP_JR) ? PC_SEL_RS : PC_SEL_LABEL;
        end
        if (op_q == OP_BR && func_q == F_BR_LINK) begin
          rf_we   = 1'b1;
          rf_wsel = RF_WSEL_LINK;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = func_q[0];
        pc_we    = dmem_ack && func_q[0];
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = (op_q == OP_MEM) ? RF_WSEL_MEM : RF_WSEL_ALU;
        pc_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);

endmodule
